// File: rtl/exc_status_ctrl_pkg.sv
// Shared processor definitions for the exception-status path.
// Holds the exception codes, the setx/bex opcodes, the controller state encoding
// and a helper that turns a 27-bit jump immediate into a 32-bit PC.
package exc_status_ctrl_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned TGT_W  = 27;
    localparam int unsigned OP_W   = 5;
    localparam int unsigned FCNT_W = 4;

    // Exception codes written into rstatus by the execute-stage detector
    localparam logic [XLEN-1:0] EXC_ADD_OVF  = 32'd1;
    localparam logic [XLEN-1:0] EXC_ADDI_OVF = 32'd2;
    localparam logic [XLEN-1:0] EXC_SUB_OVF  = 32'd3;

    // Opcodes of the instructions that touch rstatus
    localparam logic [OP_W-1:0] OP_SETX = 5'b10101;
    localparam logic [OP_W-1:0] OP_BEX  = 5'b10110;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_FLUSH    = 2'd1,
        ST_REDIRECT = 2'd2
    } state_t;

    // Jump immediates are zero-extended into the PC
    function automatic logic [XLEN-1:0] target_to_pc(input logic [TGT_W-1:0] t);
        return {5'b0, t};
    endfunction

endpackage

// File: rtl/exc_status_ctrl_status_reg.sv
// Architectural exception status register (shadow of $r30).
// Ports:
//   clock, reset_n          - clock, async active-low reset
//   status_en, status_code  - exception code from execute stage (highest priority)
//   setx_en, setx_target    - setx immediate write
//   rstatus                 - registered status value
//   status_fwd_c            - value rstatus will hold after this edge (bex forwarding)
module exc_status_ctrl_status_reg
    import exc_status_ctrl_pkg::*;
(
    input  logic             clock,
    input  logic             reset_n,
    input  logic             status_en,
    input  logic [XLEN-1:0]  status_code,
    input  logic             setx_en,
    input  logic [TGT_W-1:0] setx_target,
    output logic [XLEN-1:0]  rstatus,
    output logic [XLEN-1:0]  status_fwd_c
);

    logic [XLEN-1:0] status_next_c;

    // Detector beats setx when both retire together
    always_comb begin
        status_next_c = rstatus;
        if (status_en) begin
            status_next_c = status_code;
        end else if (setx_en) begin
            status_next_c = target_to_pc(setx_target);
        end
    end

    assign status_fwd_c = status_next_c;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rstatus <= '0;
        end else begin
            rstatus <= status_next_c;
        end
    end

endmodule

// File: rtl/exc_status_ctrl.sv
// Exception status controller: owns rstatus, resolves bex and sequences
// a fixed-length pipeline flush followed by a PC redirect to the handler.
// Ports:
//   clock, reset_n                    - clock, async active-low reset
//   status_en, status_writeReg        - execute-stage exception code
//   setx_en, setx_target              - setx write
//   bex_valid, bex_target, bex_ready  - bex handshake from decode
//   redirect_valid, redirect_pc,
//   redirect_ack                      - PC redirect to fetch
//   flush                             - kill IF/ID
//   rstatus                           - current status
//   exc_taken                         - saturating count of taken bex
module exc_status_ctrl
    import exc_status_ctrl_pkg::*;
#(
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned CNT_W        = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             status_en,
    input  logic [31:0]      status_writeReg,
    input  logic             setx_en,
    input  logic [26:0]      setx_target,
    input  logic             bex_valid,
    input  logic [26:0]      bex_target,
    output logic             bex_ready,
    output logic             redirect_valid,
    input  logic             redirect_ack,
    output logic [31:0]      redirect_pc,
    output logic             flush,
    output logic [31:0]      rstatus,
    output logic [CNT_W-1:0] exc_taken
);

    localparam logic [FCNT_W-1:0] FLUSH_LAST = FCNT_W'(FLUSH_CYCLES - 1);

    state_t            state;
    logic [FCNT_W-1:0] flush_cnt;
    logic [XLEN-1:0]   status_fwd_c;

    exc_status_ctrl_status_reg u_status_reg (
        .clock        (clock),
        .reset_n      (reset_n),
        .status_en    (status_en),
        .status_code  (status_writeReg),
        .setx_en      (setx_en),
        .setx_target  (setx_target),
        .rstatus      (rstatus),
        .status_fwd_c (status_fwd_c)
    );

    // Decode only accepts bex while no sequence is in flight
    assign bex_ready = (state == ST_IDLE);

    // Flush/redirect sequencer; flush stays high through REDIRECT
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state          <= ST_IDLE;
            flush_cnt      <= '0;
            redirect_pc    <= '0;
            redirect_valid <= 1'b0;
            flush          <= 1'b0;
            exc_taken      <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    // bex sees the status being written this same cycle
                    if (bex_valid && (status_fwd_c != '0)) begin
                        state       <= ST_FLUSH;
                        redirect_pc <= target_to_pc(bex_target);
                        flush       <= 1'b1;
                        flush_cnt   <= '0;
                    end
                end
                ST_FLUSH: begin
                    if (flush_cnt == FLUSH_LAST) begin
                        state          <= ST_REDIRECT;
                        redirect_valid <= 1'b1;
                    end else begin
                        flush_cnt <= flush_cnt + FCNT_W'(1);
                    end
                end
                ST_REDIRECT: begin
                    if (redirect_ack) begin
                        state          <= ST_IDLE;
                        redirect_valid <= 1'b0;
                        flush          <= 1'b0;
                        if (exc_taken != '1) begin
                            exc_taken <= exc_taken + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state          <= ST_IDLE;
                    redirect_valid <= 1'b0;
                    flush          <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_exc_status_ctrl.sv
// Bench for exc_status_ctrl: directed stimulus pushes expected redirect targets
// into a queue; a negedge monitor pops one per redirect and checks target,
// preceding flush length and stability while waiting for ack.
module tb_exc_status_ctrl;

    localparam int unsigned FC = 2;
    localparam int unsigned CW = 2;

    logic          clock;
    logic          reset_n;
    logic          status_en;
    logic [31:0]   status_writeReg;
    logic          setx_en;
    logic [26:0]   setx_target;
    logic          bex_valid;
    logic [26:0]   bex_target;
    logic          bex_ready;
    logic          redirect_valid;
    logic          redirect_ack;
    logic [31:0]   redirect_pc;
    logic          flush;
    logic [31:0]   rstatus;
    logic [CW-1:0] exc_taken;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [31:0] exp_q[$];

    exc_status_ctrl #(.FLUSH_CYCLES(FC), .CNT_W(CW)) dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .status_en       (status_en),
        .status_writeReg (status_writeReg),
        .setx_en         (setx_en),
        .setx_target     (setx_target),
        .bex_valid       (bex_valid),
        .bex_target      (bex_target),
        .bex_ready       (bex_ready),
        .redirect_valid  (redirect_valid),
        .redirect_ack    (redirect_ack),
        .redirect_pc     (redirect_pc),
        .flush           (flush),
        .rstatus         (rstatus),
        .exc_taken       (exc_taken)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endfunction

    // Monitor: one expected target per redirect, checked when redirect_valid rises
    int          flush_run = 0;
    logic        rv_prev   = 1'b0;
    logic [31:0] held_pc   = '0;

    always @(negedge clock) begin
        if (!reset_n) begin
            flush_run = 0;
            rv_prev   = 1'b0;
        end else begin
            if (redirect_valid && !rv_prev) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_redirect", 32'd1, 32'd0);
                end else begin
                    logic [31:0] e;
                    e = exp_q.pop_front();
                    chk("redirect_pc", redirect_pc, e);
                    chk("flush_len_before_redirect", 32'(flush_run), 32'(FC));
                end
                held_pc = redirect_pc;
            end else if (redirect_valid) begin
                chk("redirect_pc_stable", redirect_pc, held_pc);
                chk("flush_during_redirect", 32'(flush), 32'd1);
            end
            if (flush && !redirect_valid) flush_run++;
            else if (!flush) flush_run = 0;
            rv_prev = redirect_valid;
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_rv();
        int n = 0;
        while (!redirect_valid && n < 20) begin
            step();
            n++;
        end
        chk("redirect_wait_timeout", 32'(redirect_valid), 32'd1);
    endtask

    task automatic finish_seq(input logic [31:0] exp_cnt);
        wait_rv();
        redirect_ack = 1'b1;
        step();
        redirect_ack = 1'b0;
        chk("rv_after_ack", 32'(redirect_valid), 32'd0);
        chk("flush_after_ack", 32'(flush), 32'd0);
        chk("ready_after_ack", 32'(bex_ready), 32'd1);
        chk("exc_taken", 32'(exc_taken), exp_cnt);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_rstatus"}, rstatus, 32'd0);
        chk({tag, "_redirect_pc"}, redirect_pc, 32'd0);
        chk({tag, "_redirect_valid"}, 32'(redirect_valid), 32'd0);
        chk({tag, "_flush"}, 32'(flush), 32'd0);
        chk({tag, "_exc_taken"}, 32'(exc_taken), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset_n         = 1'b0;
        status_en       = 1'b0;
        status_writeReg = '0;
        setx_en         = 1'b0;
        setx_target     = '0;
        bex_valid       = 1'b0;
        bex_target      = '0;
        redirect_ack    = 1'b0;

        // Reset values
        step();
        step();
        check_reset_outputs("reset");
        reset_n = 1'b1;
        step();
        chk("ready_after_reset", 32'(bex_ready), 32'd1);

        // Detector and setx together: detector wins
        status_en       = 1'b1;
        status_writeReg = 32'd3;
        setx_en         = 1'b1;
        setx_target     = 27'h55;
        step();
        status_en = 1'b0;
        setx_en   = 1'b0;
        chk("status_priority", rstatus, 32'd3);

        // setx alone, then setx 0 clears
        setx_en     = 1'b1;
        setx_target = 27'h4ABCDEF;
        step();
        chk("setx_load", rstatus, 32'h04ABCDEF);
        setx_target = 27'h0;
        step();
        setx_en = 1'b0;
        chk("setx_clear", rstatus, 32'd0);

        // bex with zero status is consumed silently; stray ack ignored
        redirect_ack = 1'b1;
        bex_valid    = 1'b1;
        bex_target   = 27'h100;
        step();
        bex_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("no_flush_zero_status", 32'(flush), 32'd0);
            chk("ready_zero_status", 32'(bex_ready), 32'd1);
            step();
        end
        redirect_ack = 1'b0;
        chk("exc_taken_zero_status", 32'(exc_taken), 32'd0);

        // Exception write forwarded into a same-cycle bex
        status_en       = 1'b1;
        status_writeReg = 32'd1;
        bex_valid       = 1'b1;
        bex_target      = 27'h1234;
        exp_q.push_back(32'h00001234);
        step();
        status_en = 1'b0;
        bex_valid = 1'b0;
        chk("flush_first_cycle", 32'(flush), 32'd1);
        chk("ready_in_flush", 32'(bex_ready), 32'd0);
        wait_rv();
        for (int i = 0; i < 3; i++) begin
            chk("hold_rv", 32'(redirect_valid), 32'd1);
            chk("hold_pc", redirect_pc, 32'h00001234);
            step();
        end
        finish_seq(32'd1);
        chk("rstatus_not_cleared", rstatus, 32'd1);

        // bex during FLUSH is ignored, then retaken once IDLE
        bex_valid  = 1'b1;
        bex_target = 27'h200;
        exp_q.push_back(32'h00000200);
        step();
        bex_target = 27'h300;
        chk("ready_low_in_flush", 32'(bex_ready), 32'd0);
        exp_q.push_back(32'h00000300);
        finish_seq(32'd2);
        step();
        bex_valid = 1'b0;
        finish_seq(32'd3);

        // Fourth taken bex: counter saturates
        bex_valid  = 1'b1;
        bex_target = 27'h3FF;
        exp_q.push_back(32'h000003FF);
        step();
        bex_valid = 1'b0;
        finish_seq(32'd3);

        // Reset while redirect is pending
        bex_valid  = 1'b1;
        bex_target = 27'h777;
        exp_q.push_back(32'h00000777);
        step();
        bex_valid = 1'b0;
        wait_rv();
        step();
        reset_n = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        step();
        reset_n = 1'b1;
        step();
        chk("ready_after_mid_reset", 32'(bex_ready), 32'd1);
        for (int i = 0; i < 4; i++) begin
            chk("idle_after_mid_reset", 32'(flush | redirect_valid), 32'd0);
            step();
        end

        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
